// File: rtl/bidirectional_deser.sv
// Serial-to-parallel receiver for a bidirectional shift-register link.
// Reassembles LSB-first or MSB-first frames and hands words downstream via valid/ready.
module bidirectional_deser #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             dir,
    input  logic             sin,
    input  logic             bit_en,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  sh_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              dir_r;
    logic [WIDTH-1:0]  sh_next_s;
    logic              last_bit_s;

    // Next shift-register image for the latched bit order, and last-bit detect.
    always_comb begin
        sh_next_s  = sh_r;
        last_bit_s = 1'b0;
        if (dir_r) begin
            sh_next_s = {sh_r[WIDTH-2:0], sin};
        end else begin
            sh_next_s = {sin, sh_r[WIDTH-1:1]};
        end
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
    end

    // Frame FSM with registered outputs; a start in any accepting state restarts cleanly.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= IDLE;
            sh_r    <= '0;
            cnt_r   <= '0;
            dir_r   <= 1'b0;
            q       <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dir_r   <= dir;
                        sh_r    <= '0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        dir_r <= dir;
                        sh_r  <= '0;
                        cnt_r <= '0;
                    end else if (bit_en) begin
                        sh_r <= sh_next_s;
                        if (last_bit_s) begin
                            q       <= sh_next_s;
                            valid   <= 1'b1;
                            busy    <= 1'b0;
                            cnt_r   <= '0;
                            state_r <= HOLD;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (start) begin
                            dir_r   <= dir;
                            sh_r    <= '0;
                            cnt_r   <= '0;
                            busy    <= 1'b1;
                            state_r <= SHIFT;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (start) begin
                        overrun <= 1'b1;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bidirectional_deser.sv
// Self-checking bench for bidirectional_deser: directed vector table, hand sequences,
// and randomized traffic against a frame-level reference model.
module tb_bidirectional_deser;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             start = 1'b0;
    logic             dir = 1'b0;
    logic             sin = 1'b0;
    logic             bit_en = 1'b0;
    logic             ready = 1'b0;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             busy;
    logic             overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bidirectional_deser #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk(clk), .clr(clr), .start(start), .dir(dir), .sin(sin),
        .bit_en(bit_en), .ready(ready), .q(q), .valid(valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             start;
        logic             dir;
        logic             sin;
        logic             bit_en;
        logic             ready;
        logic [WIDTH-1:0] q;
        logic             valid;
        logic             busy;
        logic             ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic v(input logic s, input logic d, input logic si, input logic b, input logic r,
                     input logic [WIDTH-1:0] eq, input logic ev, input logic eb, input logic eo);
        vec_t e;
        e.start = s; e.dir = d; e.sin = si; e.bit_en = b; e.ready = r;
        e.q = eq; e.valid = ev; e.busy = eb; e.ovr = eo;
        tbl.push_back(e);
    endtask

    task automatic drive(input logic s, input logic d, input logic si, input logic b, input logic r);
        start = s; dir = d; sin = si; bit_en = b; ready = r;
        @(posedge clk);
        #1;
        start = 1'b0; bit_en = 1'b0; ready = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [WIDTH-1:0] eq, input logic ev,
                           input logic eb, input logic eo);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".valid"}, 32'(valid), 32'(ev));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".overrun"}, 32'(overrun), 32'(eo));
    endtask

    // Reference model state: frame-level view of the receiver.
    bit               m_in_frame;
    bit               m_holding;
    bit               m_dir;
    bit               m_ovr;
    logic [WIDTH-1:0] m_q;
    bit               m_bits[$];

    task automatic model_step(input bit s, input bit d, input bit si, input bit b, input bit r);
        logic [WIDTH-1:0] w;
        if (m_holding) begin
            if (r) begin
                m_holding = 1'b0;
                if (s) begin m_in_frame = 1'b1; m_dir = d; m_bits.delete(); end
            end else if (s) begin
                m_ovr = 1'b1;
            end
        end else if (s) begin
            m_in_frame = 1'b1; m_dir = d; m_bits.delete();
        end else if (m_in_frame && b) begin
            m_bits.push_back(si);
            if (m_bits.size() == WIDTH) begin
                w = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (m_dir) w[WIDTH-1-i] = m_bits[i];
                    else       w[i] = m_bits[i];
                end
                m_q = w;
                m_holding = 1'b1;
                m_in_frame = 1'b0;
                m_bits.delete();
            end
        end
    endtask

    initial begin
        logic [3:0] gap_bits;
        // LSB-first 1,1,0,0
        v(1,0,0,0,0, 4'b0000,0,1,0);
        v(0,0,1,1,0, 4'b0000,0,1,0);
        v(0,0,1,1,0, 4'b0000,0,1,0);
        v(0,0,0,1,0, 4'b0000,0,1,0);
        v(0,0,0,1,0, 4'b0011,1,0,0);
        v(0,0,0,0,0, 4'b0011,1,0,0);
        v(0,0,0,0,1, 4'b0011,0,0,0);
        // MSB-first 1,1,0,0; dir input changes after start must not matter
        v(1,1,0,0,0, 4'b0011,0,1,0);
        v(0,0,1,1,0, 4'b0011,0,1,0);
        v(0,0,1,1,0, 4'b0011,0,1,0);
        v(0,0,0,1,0, 4'b0011,0,1,0);
        v(0,0,0,1,0, 4'b1100,1,0,0);
        v(0,0,0,0,1, 4'b1100,0,0,0);
        // Restart: aborted LSB frame, start+bit_en drops the bit, then MSB 0,1,0,1
        v(1,0,0,0,0, 4'b1100,0,1,0);
        v(0,0,1,1,0, 4'b1100,0,1,0);
        v(0,0,1,1,0, 4'b1100,0,1,0);
        v(1,1,1,1,0, 4'b1100,0,1,0);
        v(0,0,0,1,0, 4'b1100,0,1,0);
        v(0,0,1,1,0, 4'b1100,0,1,0);
        v(0,0,0,1,0, 4'b1100,0,1,0);
        v(0,0,1,1,0, 4'b0101,1,0,0);
        v(0,0,0,0,1, 4'b0101,0,0,0);
        // IDLE ignores bit_en and ready
        v(0,0,1,1,1, 4'b0101,0,0,0);
        // Back-to-back: MSB 1100, then start+ready with dir=0, LSB 0,1,1,0
        v(1,1,0,0,0, 4'b0101,0,1,0);
        v(0,0,1,1,0, 4'b0101,0,1,0);
        v(0,0,1,1,0, 4'b0101,0,1,0);
        v(0,0,0,1,0, 4'b0101,0,1,0);
        v(0,0,0,1,0, 4'b1100,1,0,0);
        v(1,0,0,0,1, 4'b1100,0,1,0);
        v(0,0,0,1,0, 4'b1100,0,1,0);
        v(0,0,1,1,0, 4'b1100,0,1,0);
        v(0,0,1,1,0, 4'b1100,0,1,0);
        v(0,0,0,1,0, 4'b0110,1,0,0);
        v(0,0,0,0,1, 4'b0110,0,0,0);
        // Overrun: word 0011 pending, start without ready
        v(1,0,0,0,0, 4'b0110,0,1,0);
        v(0,0,1,1,0, 4'b0110,0,1,0);
        v(0,0,1,1,0, 4'b0110,0,1,0);
        v(0,0,0,1,0, 4'b0110,0,1,0);
        v(0,0,0,1,0, 4'b0011,1,0,0);
        v(1,0,0,0,0, 4'b0011,1,0,1);
        v(0,0,1,1,0, 4'b0011,1,0,1);
        v(0,0,0,0,1, 4'b0011,0,0,1);

        // Reset state
        #2;
        chk_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        #10 clr = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].start, tbl[i].dir, tbl[i].sin, tbl[i].bit_en, tbl[i].ready);
            chk_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].valid, tbl[i].busy, tbl[i].ovr);
        end

        // MSB-first with 3-cycle gaps between bits; overrun still sticky
        gap_bits = 4'b1100;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("gap.start.busy", 32'(busy), 32'd1);
        for (int i = 0; i < WIDTH; i++) begin
            drive(1'b0, 1'b0, gap_bits[WIDTH-1-i], 1'b1, 1'b0);
            if (i < WIDTH - 1) begin
                for (int g = 0; g < 3; g++) begin
                    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                    chk("gap.busy", 32'(busy), 32'd1);
                    chk("gap.valid", 32'(valid), 32'd0);
                end
            end
        end
        chk_all("gap.done", 4'b1100, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("gap.consumed", 4'b1100, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-frame after two bits
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("midframe.busy", 32'(busy), 32'd1);
        #2 clr = 1'b0;
        #1;
        chk_all("async_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        #3 clr = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_all("post_reset_idle", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the reference model
        m_in_frame = 1'b0; m_holding = 1'b0; m_dir = 1'b0; m_ovr = 1'b0; m_q = '0;
        m_bits.delete();
        for (int n = 0; n < 600; n++) begin
            bit rs, rd, rsi, rb, rr;
            rs  = ($urandom_range(0, 9) == 0);
            rd  = 1'($urandom);
            rsi = 1'($urandom);
            rb  = ($urandom_range(0, 2) != 0);
            rr  = ($urandom_range(0, 3) == 0);
            model_step(rs, rd, rsi, rb, rr);
            drive(rs, rd, rsi, rb, rr);
            chk_all($sformatf("rand%0d", n), m_q, m_holding, m_in_frame, m_ovr);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
